// File: rtl/sim_halt_monitor.sv
// Simulation halt monitor: watches the commit stream for EBREAK/ECALL and runs stall and
// cycle-limit watchdogs. It latches the halt cause, then drains before raising done.
module sim_halt_monitor #(
    parameter int XLEN          = 32,
    parameter int CNT_W         = 64,
    parameter int TRAP_ON_ECALL = 0,
    parameter int STALL_LIMIT   = 1000,
    parameter int MAX_CYCLES    = 0,
    parameter int DRAIN_CYCLES  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             commit_valid,
    input  logic [31:0]      commit_inst,
    input  logic [XLEN-1:0]  commit_pc,
    input  logic [XLEN-1:0]  a0,
    output logic             halted,
    output logic             done,
    output logic [1:0]       halt_cause,
    output logic             good_trap,
    output logic [XLEN-1:0]  exit_code,
    output logic [XLEN-1:0]  halt_pc,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);
    localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;
    localparam logic [31:0] INST_ECALL   = 32'h0000_0073;
    localparam logic [1:0]  CAUSE_TRAP   = 2'd1;
    localparam logic [1:0]  CAUSE_STALL  = 2'd2;
    localparam logic [1:0]  CAUSE_CYCLES = 2'd3;

    localparam int STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [STALL_W:0]    STALL_HIT  = (STALL_W + 1)'(STALL_LIMIT);
    localparam logic [CNT_W:0]      CYCLE_HIT  = (CNT_W + 1)'(MAX_CYCLES);
    localparam logic [DRAIN_W-1:0]  DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

    typedef struct packed {
        logic [1:0]      cause;
        logic            good;
        logic [XLEN-1:0] code;
        logic [XLEN-1:0] pc;
    } halt_info_t;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

    state_t             state, state_nxt;
    logic [STALL_W-1:0] stall_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [XLEN-1:0]    last_pc;
    logic [STALL_W:0]   stall_inc;
    logic [CNT_W:0]     cycle_inc;
    logic               is_trap, cycle_hit, stall_hit, detect;
    halt_info_t         info_nxt;

    // Increments are one bit wider so a saturated counter can never alias a threshold.
    always_comb begin
        stall_inc = {1'b0, stall_cnt} + (STALL_W + 1)'(1);
        cycle_inc = {1'b0, cycle_count} + (CNT_W + 1)'(1);
        is_trap   = commit_valid &&
                    ((commit_inst == INST_EBREAK) ||
                     ((TRAP_ON_ECALL != 0) && (commit_inst == INST_ECALL)));
        cycle_hit = (MAX_CYCLES != 0) && (cycle_inc == CYCLE_HIT);
        stall_hit = (STALL_LIMIT != 0) && !commit_valid && (stall_inc == STALL_HIT);
        detect    = is_trap || cycle_hit || stall_hit;
    end

    // Trap beats cycle limit beats stall; a same-cycle commit counts as the last PC.
    always_comb begin
        info_nxt.cause = CAUSE_STALL;
        info_nxt.good  = 1'b0;
        info_nxt.code  = '1;
        info_nxt.pc    = last_pc;
        if (is_trap) begin
            info_nxt.cause = CAUSE_TRAP;
            info_nxt.good  = (a0 == '0);
            info_nxt.code  = a0;
            info_nxt.pc    = commit_pc;
        end else if (cycle_hit) begin
            info_nxt.cause = CAUSE_CYCLES;
            if (commit_valid) info_nxt.pc = commit_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= S_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (detect) state_nxt = (DRAIN_CYCLES == 0) ? S_HALTED : S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt <= DRAIN_W'(1)) state_nxt = S_HALTED;
            end
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            halted        <= 1'b0;
            done          <= 1'b0;
            halt_cause    <= '0;
            good_trap     <= 1'b0;
            exit_code     <= '0;
            halt_pc       <= '0;
            cycle_count   <= '0;
            instret_count <= '0;
            stall_cnt     <= '0;
            drain_cnt     <= '0;
            last_pc       <= '0;
        end else begin
            halted <= (state_nxt != S_RUN);
            done   <= (state_nxt == S_HALTED);
            case (state)
                S_RUN: begin
                    if (~&cycle_count) cycle_count <= cycle_inc[CNT_W-1:0];
                    if (commit_valid) begin
                        if (~&instret_count) instret_count <= instret_count + CNT_W'(1);
                        last_pc   <= commit_pc;
                        stall_cnt <= '0;
                    end else if (~&stall_cnt) begin
                        stall_cnt <= stall_inc[STALL_W-1:0];
                    end
                    if (detect) begin
                        halt_cause <= info_nxt.cause;
                        good_trap  <= info_nxt.good;
                        exit_code  <= info_nxt.code;
                        halt_pc    <= info_nxt.pc;
                        drain_cnt  <= DRAIN_LOAD;
                    end
                end
                S_DRAIN: drain_cnt <= drain_cnt - DRAIN_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sim_halt_monitor.sv
// Bench for sim_halt_monitor: four differently parameterised monitors share one commit stream
// and are compared every cycle against an edge-counting reference model, plus pinned literals.
module tb_sim_halt_monitor;
    localparam int NI = 4;
    localparam int P_ECALL[NI] = '{0, 1, 0, 1};
    localparam int P_STALL[NI] = '{5, 5, 0, 3};
    localparam int P_MAX[NI]   = '{0, 0, 10, 7};
    localparam int P_DRAIN[NI] = '{4, 4, 0, 1};
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cv    = 1'b0;
    logic [31:0] inst  = NOP;
    logic [31:0] pc    = '0;
    logic [31:0] a0    = '0;

    logic [NI-1:0] halted, done, good;
    logic [1:0]    cause [NI];
    logic [31:0]   exitc [NI];
    logic [31:0]   hpc   [NI];
    logic [63:0]   cyc   [NI];
    logic [63:0]   ins   [NI];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sim_halt_monitor #(
            .XLEN(32), .CNT_W(64), .TRAP_ON_ECALL(P_ECALL[g]), .STALL_LIMIT(P_STALL[g]),
            .MAX_CYCLES(P_MAX[g]), .DRAIN_CYCLES(P_DRAIN[g])
        ) u_dut (
            .clock(clock), .reset(reset), .commit_valid(cv), .commit_inst(inst),
            .commit_pc(pc), .a0(a0), .halted(halted[g]), .done(done[g]),
            .halt_cause(cause[g]), .good_trap(good[g]), .exit_code(exitc[g]),
            .halt_pc(hpc[g]), .cycle_count(cyc[g]), .instret_count(ins[g])
        );
    end

    // Reference model: "run" until a halt is seen, then count edges since detection.
    bit          m_run   [NI];
    int          m_since [NI];
    longint      m_cyc   [NI];
    longint      m_ins   [NI];
    int          m_idle  [NI];
    logic [31:0] m_last  [NI];
    logic [31:0] m_exit  [NI];
    logic [31:0] m_hpc   [NI];
    logic [1:0]  m_cause [NI];
    bit          m_good  [NI];

    task automatic model_step();
        bit trap, lim, stl;
        for (int i = 0; i < NI; i++) begin
            if (!reset) begin
                m_run[i] = 1; m_since[i] = 0; m_cyc[i] = 0; m_ins[i] = 0; m_idle[i] = 0;
                m_last[i] = 0; m_exit[i] = 0; m_hpc[i] = 0; m_cause[i] = 0; m_good[i] = 0;
            end else if (!m_run[i]) begin
                m_since[i]++;
            end else begin
                trap = cv && (inst == EBREAK || (P_ECALL[i] != 0 && inst == ECALL));
                lim  = P_MAX[i] != 0 && m_cyc[i] + 1 == longint'(P_MAX[i]);
                stl  = P_STALL[i] != 0 && !cv && m_idle[i] + 1 == P_STALL[i];
                m_cyc[i]++;
                if (cv) begin m_ins[i]++; m_idle[i] = 0; m_last[i] = pc; end
                else    m_idle[i]++;
                if (trap) begin
                    m_cause[i] = 1; m_exit[i] = a0; m_hpc[i] = pc; m_good[i] = (a0 == 0);
                end else if (lim) begin
                    m_cause[i] = 3; m_exit[i] = '1; m_hpc[i] = m_last[i]; m_good[i] = 0;
                end else if (stl) begin
                    m_cause[i] = 2; m_exit[i] = '1; m_hpc[i] = m_last[i]; m_good[i] = 0;
                end
                if (trap || lim || stl) begin m_run[i] = 0; m_since[i] = 0; end
            end
        end
    endtask

    task automatic chk(input string nm, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] @%0t: got %0h, expected %0h", nm, idx, $time, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk("halted", i, halted[i], !m_run[i]);
                chk("done",   i, done[i],   !m_run[i] && m_since[i] >= P_DRAIN[i]);
                chk("cause",  i, cause[i],  m_cause[i]);
                chk("good",   i, good[i],   m_good[i]);
                chk("exit",   i, exitc[i],  m_exit[i]);
                chk("hpc",    i, hpc[i],    m_hpc[i]);
                chk("cycle",  i, cyc[i],    m_cyc[i]);
                chk("instret",i, ins[i],    m_ins[i]);
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] ii, input logic [31:0] p,
                        input logic [31:0] a);
        cv = v; inst = ii; pc = p; a0 = a;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0; cv = 1'b0; inst = NOP;
        @(posedge clock);
        chk_en = 1'b1;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int len, p, r;
        logic        v;
        logic [31:0] ii;

        @(negedge clock);
        // Good trap at edge 4, drain of 4
        do_reset();
        chk("L_rst_halted", 0, halted[0], 0);
        chk("L_rst_cycle", 0, cyc[0], 0);
        step(1, NOP, 32'h8000_0004, 5);
        step(1, NOP, 32'h8000_0008, 0);
        step(1, NOP, 32'h8000_000c, 7);
        chk("L_A_pre", 0, halted[0], 0);
        step(1, EBREAK, 32'h8000_0010, 0);
        chk("L_A_halted", 0, halted[0], 1);
        chk("L_A_done0", 0, done[0], 0);
        chk("L_A_cause", 0, cause[0], 1);
        chk("L_A_good", 0, good[0], 1);
        chk("L_A_exit", 0, exitc[0], 0);
        chk("L_A_hpc", 0, hpc[0], 32'h8000_0010);
        chk("L_A_instret", 0, ins[0], 4);
        chk("L_A_cycle", 0, cyc[0], 4);
        repeat (3) step(0, NOP, 0, 0);
        chk("L_A_done7", 0, done[0], 0);
        step(0, NOP, 0, 0);
        chk("L_A_done8", 0, done[0], 1);
        chk("L_A_frozen", 0, cyc[0], 4);

        // Bad trap, then a second EBREAK during drain
        do_reset();
        step(1, EBREAK, 32'h8000_0100, 1);
        chk("L_B_good", 0, good[0], 0);
        chk("L_B_exit", 0, exitc[0], 1);
        step(1, EBREAK, 32'h8000_0200, 0);
        chk("L_B_exit2", 0, exitc[0], 1);
        chk("L_B_hpc2", 0, hpc[0], 32'h8000_0100);
        chk("L_B_instret", 0, ins[0], 1);

        // Stall timeout after 5 idle edges
        do_reset();
        step(1, NOP, 32'h8000_0000, 0);
        repeat (4) step(0, NOP, 0, 0);
        chk("L_C_pre", 0, halted[0], 0);
        step(0, NOP, 0, 0);
        chk("L_C_halted", 0, halted[0], 1);
        chk("L_C_cause", 0, cause[0], 2);
        chk("L_C_exit", 0, exitc[0], 32'hFFFF_FFFF);
        chk("L_C_hpc", 0, hpc[0], 32'h8000_0000);

        // Commit on the threshold cycle prevents the stall halt
        do_reset();
        step(1, NOP, 32'h8000_0000, 0);
        repeat (4) step(0, NOP, 0, 0);
        step(1, NOP, 32'h8000_0004, 0);
        chk("L_C2_nohalt", 0, halted[0], 0);
        step(0, NOP, 0, 0);
        chk("L_C2_nohalt2", 0, halted[0], 0);

        // Cycle limit coinciding with a trap: trap wins
        do_reset();
        for (int k = 1; k <= 9; k++) step(1, NOP, 32'h8000_0000 + 32'(4 * k), 0);
        chk("L_D_pre", 2, halted[2], 0);
        step(1, EBREAK, 32'h8000_0028, 3);
        chk("L_D_cause", 2, cause[2], 1);
        chk("L_D_cycle", 2, cyc[2], 10);
        chk("L_D_done", 2, done[2], 1);
        chk("L_D_exit", 2, exitc[2], 3);

        // Cycle limit alone
        do_reset();
        for (int k = 1; k <= 10; k++) step(1, NOP, 32'h8000_0000 + 32'(4 * k), 0);
        chk("L_D2_cause", 2, cause[2], 3);
        chk("L_D2_cycle", 2, cyc[2], 10);
        chk("L_D2_exit", 2, exitc[2], 32'hFFFF_FFFF);

        // ECALL halts only when enabled
        do_reset();
        step(1, ECALL, 32'h8000_0040, 0);
        chk("L_E_off", 0, halted[0], 0);
        chk("L_E_on", 1, halted[1], 1);
        chk("L_E_cause", 1, cause[1], 1);

        // Reset during drain, then a fresh run
        do_reset();
        step(1, EBREAK, 32'h8000_0010, 0);
        chk("L_F_halted", 0, halted[0], 1);
        reset = 1'b0;
        step(0, NOP, 0, 0);
        chk("L_F_rhalted", 0, halted[0], 0);
        chk("L_F_rcause", 0, cause[0], 0);
        chk("L_F_rhpc", 0, hpc[0], 0);
        chk("L_F_rcycle", 0, cyc[0], 0);
        reset = 1'b1;
        step(1, NOP, 32'h8000_0018, 0);
        step(1, NOP, 32'h8000_001c, 0);
        step(1, EBREAK, 32'h8000_0020, 9);
        chk("L_F_halted2", 0, halted[0], 1);
        chk("L_F_cycle", 0, cyc[0], 3);
        chk("L_F_instret", 0, ins[0], 3);
        chk("L_F_exit", 0, exitc[0], 9);

        // Randomised segments with varying commit density
        for (int s = 0; s < 30; s++) begin
            len = $urandom_range(5, 40);
            p   = $urandom_range(0, 3);
            do_reset();
            for (int k = 0; k < len; k++) begin
                v  = ($urandom_range(0, 2) < p);
                r  = $urandom_range(0, 99);
                ii = (r < 5) ? EBREAK : (r < 10) ? ECALL : 32'($urandom);
                step(v, ii, 32'($urandom) & 32'hFFFF_FFFC,
                     ($urandom_range(0, 2) == 0) ? 32'h0 : 32'($urandom));
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
